// File: rtl/bf16_divider_seq_pkg.sv
// Shared constants, iteration count and FSM encoding for the bf16 divider.
// Optional feature macro: BF16_DIV_ROUND_EN (guard bit + sticky, round-to-nearest-even).
package bf16_divider_seq_pkg;

  localparam int          BF16_BIAS = 127;
  localparam logic [14:0] BF16_ZERO = 15'h0000;
  localparam logic [14:0] BF16_INF  = 15'h7F80;

`ifdef BF16_DIV_ROUND_EN
  localparam int ITER     = 10;
  localparam bit ROUND_EN = 1'b1;
`else
  localparam int ITER     = 9;
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_DIV  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/bf16_lzc8.sv
// 8-bit leading-zero counter; returns 8 for an all-zero input.
module bf16_lzc8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = 4'd8;
    // Scan upward so the highest set bit is the one that sticks.
    for (int i = 0; i < 8; i++) begin
      if (din[i]) cnt = 4'(7 - i);
    end
  end

endmodule

// File: rtl/bf16_divider_seq.sv
// Iterative bf16 divider, restoring radix-2, one quotient bit per cycle.
// Build macro BF16_DIV_ROUND_EN enables round-to-nearest-even (one extra DIV cycle).
module bf16_divider_seq
  import bf16_divider_seq_pkg::*;
#(
  parameter int BIAS = BF16_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quo
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  state_t                   state_q, state_d;
  logic [15:0]              a_q, a_d, b_q, b_d;
  logic [7:0]               mb_q, mb_d;
  logic signed [9:0]        e_q, e_d;
  logic [8:0]               rem_q, rem_d;
  logic [ITER-1:0]          q_q, q_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic [15:0]              quo_q, quo_d;
  logic                     out_valid_q, out_valid_d;

  logic [3:0]               lzc_a, lzc_b;
  logic [7:0]               ma, mb;
  logic signed [9:0]        ea_eff, eb_eff, e_n, sh;
  logic                     ge, guard, sticky, inc;
  logic [8:0]               rem_sel;
  logic [6:0]               frac;
  logic [15:0]              wide;
  logic [14:0]              body;

  bf16_lzc8 u_lzc_a (.din({1'b0, a_q[6:0]}), .cnt(lzc_a));
  bf16_lzc8 u_lzc_b (.din({1'b0, b_q[6:0]}), .cnt(lzc_b));

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign quo       = quo_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mb_d        = mb_q;
    e_d         = e_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    quo_d       = quo_q;
    out_valid_d = out_valid_q;
    ma          = 8'h00;
    mb          = 8'h00;
    ea_eff      = '0;
    eb_eff      = '0;
    e_n         = '0;
    sh          = '0;
    ge          = 1'b0;
    rem_sel     = '0;
    frac        = '0;
    guard       = 1'b0;
    sticky      = 1'b0;
    inc         = 1'b0;
    wide        = '0;
    body        = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = num1;
          b_d     = num2;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        sign_d = a_q[15] ^ b_q[15];
        if (a_q[14:7] == 8'hFF || b_q[14:7] == 8'hFF || b_q[14:0] == 15'h0) begin
          quo_d       = {a_q[15] ^ b_q[15], BF16_INF};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (a_q[14:0] == 15'h0) begin
          quo_d       = {a_q[15] ^ b_q[15], BF16_ZERO};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          // Subnormals are normalised here so DIV always sees mantissas in [1,2).
          if (a_q[14:7] == 8'h00) begin
            ma     = {1'b0, a_q[6:0]} << lzc_a;
            ea_eff = 10'sd1 - $signed({6'b0, lzc_a});
          end else begin
            ma     = {1'b1, a_q[6:0]};
            ea_eff = $signed({2'b0, a_q[14:7]});
          end
          if (b_q[14:7] == 8'h00) begin
            mb     = {1'b0, b_q[6:0]} << lzc_b;
            eb_eff = 10'sd1 - $signed({6'b0, lzc_b});
          end else begin
            mb     = {1'b1, b_q[6:0]};
            eb_eff = $signed({2'b0, b_q[14:7]});
          end
          rem_d   = {1'b0, ma};
          mb_d    = mb;
          e_d     = ea_eff - eb_eff + BIAS_S;
          q_d     = '0;
          cnt_d   = 4'd0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sel = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d   = rem_sel << 1;
        q_d     = {q_q[ITER-2:0], ge};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = S_POST;
      end

      S_POST: begin
        e_n = q_q[ITER-1] ? e_q : (e_q - 10'sd1);
`ifdef BF16_DIV_ROUND_EN
        if (q_q[ITER-1]) begin
          frac   = q_q[8:2];
          guard  = q_q[1];
          sticky = q_q[0] | (|rem_q);
        end else begin
          frac   = q_q[7:1];
          guard  = q_q[0];
          sticky = |rem_q;
        end
`else
        frac = q_q[ITER-1] ? q_q[7:1] : q_q[6:0];
`endif
        sh = 10'sd1 - e_n;
        if (e_n >= 10'sd255) begin
          quo_d = {sign_q, BF16_INF};
        end else if (e_n <= 10'sd0) begin
          if (sh > 10'sd8) begin
            quo_d = {sign_q, BF16_ZERO};
          end else begin
            // Denormalise with guard/sticky carried along so rounding follows the shift.
            wide   = {1'b1, frac, guard, 7'b0} >> sh[3:0];
            body   = {8'h00, wide[14:8]};
            inc    = ROUND_EN & wide[7] & (sticky | (|wide[6:0]) | wide[8]);
            quo_d  = {sign_q, body + {14'b0, inc}};
            guard  = wide[15];
          end
        end else begin
          body  = {e_n[7:0], frac};
          // A mantissa carry ripples into the exponent field, possibly up to INF.
          inc   = ROUND_EN & guard & (sticky | frac[0]);
          quo_d = {sign_q, body + {14'b0, inc}};
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mb_q        <= '0;
      e_q         <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      quo_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mb_q        <= mb_d;
      e_q         <= e_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      quo_q       <= quo_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
